calc_entry_fsm: RTL and testbench

Keypad entry sequencer for the calculator datapath. It turns single-cycle key events into decimal operands A and B and an operation code, and drives them to the ALU. It captures the ALU result on '=' or on chained operators, holds the displayed value, and flags divide-by-zero errors. It sits directly upstream of the ALU and closes the loop on its result.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/dec_accum.sv | 19 +
 rtl/calc_entry_fsm.sv | 142 ++++++++++++++
 tb/tb_calc_entry_fsm.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared key/op encodings and state type for the calculator entry path.
// The op codes match the ALU encoding.
package calc_pkg;
   localparam logic [3:0] OP_ADD  = 4'hA;
   localparam logic [3:0] OP_SUB  = 4'hB;
   localparam logic [3:0] OP_MUL  = 4'hC;
   localparam logic [3:0] OP_DIV  = 4'hD;
   localparam logic [3:0] KEY_EQ  = 4'hE;
   localparam logic [3:0] KEY_CLR = 4'hF;

   typedef enum logic [1:0] {S_A, S_B, S_RES, S_ERR} state_t;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

   function automatic logic is_op(input logic [3:0] k);
      return (k >= OP_ADD) && (k <= OP_DIV);
   endfunction
endpackage

// File: rtl/dec_accum.sv
// Decimal digit accumulator: next = cur*10 + digit, with overflow flagged
// when the widened result no longer fits in WIDTH bits.
module dec_accum #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] cur,
   input  logic [3:0]       digit,
   output logic [WIDTH-1:0] next,
   output logic             ovf
);
   localparam logic [WIDTH+3:0] TEN = (WIDTH+4)'(10);

   logic [WIDTH+3:0] wide;

   // Four extra bits always hold cur*10+9 without loss.
   assign wide = ({4'b0000, cur} * TEN) + {{WIDTH{1'b0}}, digit};
   assign next = wide[WIDTH-1:0];
   assign ovf  = |wide[WIDTH+3:WIDTH];
endmodule

// File: rtl/calc_entry_fsm.sv
// Keypad entry sequencer: builds operands A/B and the op for the ALU,
// folds the ALU result back on '=' or chained operators.
module calc_entry_fsm
   import calc_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_valid,
   input  logic [3:0]       key_code,
   input  logic [WIDTH-1:0] alu_res,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] disp_val,
   output logic             err
);
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, disp_q, disp_d;
   logic [3:0]       op_q, op_d;
   logic             bs_q, bs_d, err_q, err_d;

   logic [WIDTH-1:0] acc_cur, acc_next;
   logic             acc_ovf, div_zero;

   // One accumulator serves both operands; only S_B accumulates into B.
   assign acc_cur = (state_q == S_B) ? b_q : a_q;

   dec_accum #(.WIDTH(WIDTH)) u_accum (
      .cur   (acc_cur),
      .digit (key_code),
      .next  (acc_next),
      .ovf   (acc_ovf)
   );

   assign div_zero = (op_q == OP_DIV) && (b_q == '0);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      bs_d    = bs_q;
      if (key_valid) begin
         if (key_code == KEY_CLR) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = OP_ADD;
            bs_d    = 1'b0;
         end else begin
            unique case (state_q)
               S_A: begin
                  if (is_digit(key_code)) begin
                     if (!acc_ovf) a_d = acc_next;
                  end else if (is_op(key_code)) begin
                     op_d    = key_code;
                     b_d     = '0;
                     bs_d    = 1'b0;
                     state_d = S_B;
                  end
               end
               S_B: begin
                  if (is_digit(key_code)) begin
                     if (!acc_ovf) b_d = acc_next;
                     bs_d = 1'b1;
                  end else if (is_op(key_code)) begin
                     if (!bs_q) begin
                        op_d = key_code;
                     end else if (div_zero) begin
                        state_d = S_ERR;
                     end else begin
                        a_d  = alu_res;
                        op_d = key_code;
                        b_d  = '0;
                        bs_d = 1'b0;
                     end
                  end else if (key_code == KEY_EQ) begin
                     if (div_zero) state_d = S_ERR;
                     else begin
                        a_d     = alu_res;
                        state_d = S_RES;
                     end
                  end
               end
               S_RES: begin
                  if (is_digit(key_code)) begin
                     a_d     = WIDTH'(key_code);
                     b_d     = '0;
                     bs_d    = 1'b0;
                     state_d = S_A;
                  end else if (is_op(key_code)) begin
                     op_d    = key_code;
                     b_d     = '0;
                     bs_d    = 1'b0;
                     state_d = S_B;
                  end else if (key_code == KEY_EQ) begin
                     if (div_zero) state_d = S_ERR;
                     else a_d = alu_res;
                  end
               end
               default: ;
            endcase
         end
      end

      // Display tracks the post-key state so it is valid with the operands.
      unique case (state_d)
         S_B:     disp_d = bs_d ? b_d : a_d;
         S_ERR:   disp_d = '0;
         default: disp_d = a_d;
      endcase
      err_d = (state_d == S_ERR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_ADD;
         bs_q    <= 1'b0;
         disp_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         bs_q    <= bs_d;
         disp_q  <= disp_d;
         err_q   <= err_d;
      end
   end

   assign alu_a    = a_q;
   assign alu_b    = b_q;
   assign alu_op   = op_q;
   assign disp_val = disp_q;
   assign err      = err_q;
endmodule

// File: tb/tb_calc_entry_fsm.sv
// Bench for calc_entry_fsm: directed keypad scenarios plus random key streams
// checked against a calculator model kept in plain integer arithmetic.
module tb_calc_entry_fsm;
   localparam int W = 16;

   logic         clk;
   logic         rst_n;
   logic         key_valid;
   logic [3:0]   key_code;
   logic [W-1:0] alu_res;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [3:0]   alu_op;
   logic [W-1:0] disp_val;
   logic         err;

   int n_cmp;
   int n_err;

   // calculator model: mode 0 entering A, 1 entering B, 2 result shown, 3 error
   int m_a, m_b, m_op, m_mode;
   bit m_started;

   calc_entry_fsm #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_code  (key_code),
      .alu_res   (alu_res),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .disp_val  (disp_val),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int alu_int(input int a, input int b, input int op);
      longint p;
      case (op)
         10:      return (a + b) % 65536;
         11:      return (a - b + 65536) % 65536;
         12:      begin p = longint'(a) * longint'(b); return int'(p % 65536); end
         13:      return (b == 0) ? 0 : a / b;
         default: return 0;
      endcase
   endfunction

   always_comb alu_res = W'(alu_int(int'(alu_a), int'(alu_b), int'(alu_op)));

   function automatic int exp_disp();
      if (m_mode == 3) return 0;
      if (m_mode == 1 && m_started) return m_b;
      return m_a;
   endfunction

   task automatic model_reset();
      m_a = 0; m_b = 0; m_op = 10; m_mode = 0; m_started = 0;
   endtask

   task automatic model_key(input int k);
      int n;
      if (k == 15) model_reset();
      else if (m_mode == 3) ;
      else if (k <= 9) begin
         if (m_mode == 2) begin
            m_a = k; m_b = 0; m_started = 0; m_mode = 0;
         end else if (m_mode == 0) begin
            n = m_a * 10 + k;
            if (n <= 65535) m_a = n;
         end else begin
            n = m_b * 10 + k;
            if (n <= 65535) m_b = n;
            m_started = 1;
         end
      end else if (k <= 13) begin
         if (m_mode != 1) begin
            m_op = k; m_b = 0; m_started = 0; m_mode = 1;
         end else if (!m_started) m_op = k;
         else if (m_op == 13 && m_b == 0) m_mode = 3;
         else begin
            m_a = alu_int(m_a, m_b, m_op); m_op = k; m_b = 0; m_started = 0;
         end
      end else if (m_mode != 0) begin
         if (m_op == 13 && m_b == 0) m_mode = 3;
         else begin
            m_a = alu_int(m_a, m_b, m_op); m_mode = 2;
         end
      end
   endtask

   task automatic press(input int k);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = 4'(k);
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      key_code  = 4'h0;
      model_key(k);
   endtask

   task automatic test_reset();
      #12;
      n_cmp++;
      if ({alu_a, alu_b, alu_op, disp_val, err} !== {16'd0, 16'd0, 4'hA, 16'd0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_init got a=%0d b=%0d op=%h d=%0d e=%b want 0 0 a 0 0",
                  alu_a, alu_b, alu_op, disp_val, err);
      end
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      press(1); press(2); press(10); press(3);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({alu_a, alu_b, alu_op, disp_val, err} !== {16'd0, 16'd0, 4'hA, 16'd0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_async got a=%0d b=%0d op=%h d=%0d e=%b want 0 0 a 0 0",
                  alu_a, alu_b, alu_op, disp_val, err);
      end
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      press(4);
      n_cmp++;
      if (disp_val !== 16'd4 || alu_a !== 16'd4) begin
         n_err++;
         $display("FAIL reset_state_a got d=%0d a=%0d want 4 4", disp_val, alu_a);
      end
   endtask

   task automatic test_add_repeat();
      int keys[7] = '{1, 2, 10, 3, 4, 14, 14};
      int dexp[7] = '{1, 12, 12, 3, 34, 46, 80};
      press(15);
      for (int i = 0; i < 7; i++) begin
         press(keys[i]);
         n_cmp++;
         if (disp_val !== 16'(dexp[i])) begin
            n_err++;
            $display("FAIL add_repeat step%0d got %0d want %0d", i, disp_val, dexp[i]);
         end
         if (i == 5) begin
            n_cmp++;
            if (alu_a !== 16'd46) begin
               n_err++;
               $display("FAIL add_repeat_a got %0d want 46", alu_a);
            end
         end
      end
   endtask

   task automatic test_chain();
      int keys[15] = '{2, 10, 3, 12, 4, 14, 15, 8, 10, 11, 3, 14, 15, 3, 11};
      int dexp[15] = '{2, 2, 3, 5, 4, 20, 0, 8, 8, 8, 3, 5, 0, 3, 3};
      press(15);
      for (int i = 0; i < 15; i++) begin
         press(keys[i]);
         n_cmp++;
         if (disp_val !== 16'(dexp[i])) begin
            n_err++;
            $display("FAIL chain step%0d got %0d want %0d", i, disp_val, dexp[i]);
         end
      end
      press(5); press(14);
      n_cmp++;
      if (disp_val !== 16'd65534) begin
         n_err++;
         $display("FAIL sub_wrap got %0d want 65534", disp_val);
      end
   endtask

   task automatic test_overflow();
      int keys[6] = '{6, 5, 5, 3, 5, 6};
      int dexp[6] = '{6, 65, 655, 6553, 65535, 65535};
      press(15);
      for (int i = 0; i < 6; i++) begin
         press(keys[i]);
         n_cmp++;
         if (disp_val !== 16'(dexp[i])) begin
            n_err++;
            $display("FAIL overflow step%0d got %0d want %0d", i, disp_val, dexp[i]);
         end
      end
      press(15);
      press(3); press(0); press(0); press(12); press(3); press(0); press(0); press(14);
      n_cmp++;
      if (disp_val !== 16'd24464) begin
         n_err++;
         $display("FAIL mul_trunc got %0d want 24464", disp_val);
      end
   endtask

   task automatic test_div_zero();
      int keys[7] = '{9, 13, 0, 14, 5, 14, 15};
      int dexp[7] = '{9, 9, 0, 0, 0, 0, 0};
      bit eexp[7] = '{0, 0, 0, 1, 1, 1, 0};
      press(15);
      for (int i = 0; i < 7; i++) begin
         press(keys[i]);
         n_cmp++;
         if (disp_val !== 16'(dexp[i]) || err !== eexp[i]) begin
            n_err++;
            $display("FAIL div_zero step%0d got d=%0d e=%b want d=%0d e=%b",
                     i, disp_val, err, dexp[i], eexp[i]);
         end
         if (i == 5) begin
            n_cmp++;
            if (alu_a !== 16'd9) begin
               n_err++;
               $display("FAIL div_zero_a got %0d want 9", alu_a);
            end
         end
      end
      press(7);
      n_cmp++;
      if (disp_val !== 16'd7) begin
         n_err++;
         $display("FAIL div_zero_clear got %0d want 7", disp_val);
      end
   endtask

   task automatic test_result_reuse();
      int keys[8] = '{7, 12, 6, 14, 12, 2, 14, 5};
      int dexp[8] = '{7, 7, 6, 42, 42, 2, 84, 5};
      press(15);
      for (int i = 0; i < 8; i++) begin
         press(keys[i]);
         n_cmp++;
         if (disp_val !== 16'(dexp[i])) begin
            n_err++;
            $display("FAIL reuse step%0d got %0d want %0d", i, disp_val, dexp[i]);
         end
      end
      n_cmp++;
      if (alu_a !== 16'd5 || alu_b !== 16'd0) begin
         n_err++;
         $display("FAIL reuse_new_a got a=%0d b=%0d want 5 0", alu_a, alu_b);
      end
   endtask

   function automatic int rand_key();
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 50) return int'($urandom_range(0, 9));
      if (r < 58) return 0;
      if (r < 78) return int'($urandom_range(10, 13));
      if (r < 94) return 14;
      return 15;
   endfunction

   task automatic test_random(input int nkeys, input bit gaps);
      int k;
      int fails;
      fails = 0;
      press(15);
      for (int i = 0; i < nkeys; i++) begin
         k = rand_key();
         press(k);
         if (gaps && $urandom_range(0, 3) == 0) begin
            repeat (int'($urandom_range(1, 3))) @(posedge clk);
            #1;
         end
         n_cmp++;
         if ({alu_a, alu_b, alu_op, disp_val, err} !==
             {16'(m_a), 16'(m_b), 4'(m_op), 16'(exp_disp()), m_mode == 3}) begin
            n_err++;
            fails++;
            if (fails <= 5)
               $display("FAIL %s key%0d=%0d got a=%0d b=%0d op=%h d=%0d e=%b want a=%0d b=%0d op=%h d=%0d e=%0d",
                        gaps ? "random_gaps" : "back_to_back", i, k, alu_a, alu_b, alu_op,
                        disp_val, err, m_a, m_b, m_op, exp_disp(), m_mode == 3);
         end
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      key_valid = 1'b0;
      key_code  = 4'h0;
      model_reset();
      test_reset();
      test_add_repeat();
      test_chain();
      test_overflow();
      test_div_zero();
      test_result_reuse();
      test_random(400, 1'b1);
      test_random(400, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
